// File: rtl/cpu_mem_pkg.sv
// Shared MEM-stage definitions: access-width encodings (also used by the
// load-extension stage) and the access controller state encoding.
package cpu_mem_pkg;

    localparam logic [1:0] WIDTH_WORD = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-bus handshake between the MEM-stage access controller (master) and
// the data memory or peripheral bridge (slave).
interface mem_access_ctrl_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/mem_access_ctrl_lane.sv
// Byte-lane generator: turns address low bits, access width and right-aligned
// store data into byte enables, lane-replicated write data and a misalign flag.
module byte_lane_gen
    import cpu_mem_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  width_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o
);

    // Lane decode; the reserved width code is reported as misaligned
    always_comb begin
        be_o         = 4'b0000;
        wdata_o      = 32'h0;
        misaligned_o = 1'b0;
        case (width_i)
            WIDTH_WORD: begin
                be_o         = 4'b1111;
                wdata_o      = wdata_i;
                misaligned_o = (addr_lo_i != 2'b00);
            end
            WIDTH_HALF: begin
                be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o      = {2{wdata_i[15:0]}};
                misaligned_o = addr_lo_i[0];
            end
            WIDTH_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            default: misaligned_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: accepts one load/store per
// instruction, runs the req/ack bus handshake with a timeout, stalls the
// pipeline while outstanding and hands the raw read word plus access
// attributes to the load-extension stage.
module mem_access_ctrl
    import cpu_mem_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
)(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req_valid,
    input  logic               req_we,
    input  logic [31:0]        req_addr,
    input  logic [1:0]         req_width,
    input  logic               req_signed,
    input  logic [31:0]        req_wdata,
    input  logic               flush,
    output logic               stall,
    output logic               exc_adel,
    output logic               exc_ades,
    mem_access_ctrl_if.master  bus,
    output logic               rsp_valid,
    output logic               rsp_err,
    output logic [31:0]        rsp_rdata,
    output logic [1:0]         rsp_addr_lo,
    output logic [1:0]         rsp_width,
    output logic               rsp_signed
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e          state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            kill_q;
    logic            bus_req_q, we_q, signed_q;
    logic [29:0]     waddr_q;
    logic [1:0]      addr_lo_q, width_q;
    logic [3:0]      be_q;
    logic [31:0]     wdata_q;
    logic            rsp_valid_q, rsp_err_q, rsp_signed_q;
    logic [31:0]     rsp_rdata_q;
    logic [1:0]      rsp_addr_lo_q, rsp_width_q;

    logic [3:0]      lane_be;
    logic [31:0]     lane_wdata;
    logic            misaligned;
    logic            new_req, accept, ack_hit, to_hit, done, killed;

    byte_lane_gen u_lane (
        .addr_lo_i    (req_addr[1:0]),
        .width_i      (req_width),
        .wdata_i      (req_wdata),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata),
        .misaligned_o (misaligned)
    );

    // Request qualification and completion conditions for the current cycle
    always_comb begin
        new_req = (state_q == IDLE) && req_valid && !flush;
        accept  = new_req && !misaligned;
        ack_hit = (state_q == BUSY) && bus.bus_ack;
        to_hit  = (state_q == BUSY) && !bus.bus_ack && (cnt_q == CNT_LAST);
        done    = ack_hit || to_hit;
        killed  = kill_q || flush;
        cnt_d   = cnt_q + CNT_W'(1);
    end

    // A killed access releases the pipeline on its completing cycle; a live one
    // keeps stalling until the RESP cycle. Reset forces every output low.
    assign stall    = reset_n && (accept || ((state_q == BUSY) && !(killed && done)));
    assign exc_adel = reset_n && new_req && misaligned && !req_we;
    assign exc_ades = reset_n && new_req && misaligned && req_we;

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = {waddr_q, 2'b00};
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;

    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_addr_lo = rsp_addr_lo_q;
    assign rsp_width   = rsp_width_q;
    assign rsp_signed  = rsp_signed_q;

    // Access FSM: latch request, hold bus handshake, count timeout, register response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            kill_q        <= 1'b0;
            bus_req_q     <= 1'b0;
            we_q          <= 1'b0;
            signed_q      <= 1'b0;
            waddr_q       <= '0;
            addr_lo_q     <= '0;
            width_q       <= '0;
            be_q          <= '0;
            wdata_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_addr_lo_q <= '0;
            rsp_width_q   <= '0;
            rsp_signed_q  <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        waddr_q   <= req_addr[31:2];
                        addr_lo_q <= req_addr[1:0];
                        we_q      <= req_we;
                        width_q   <= req_width;
                        signed_q  <= req_signed;
                        be_q      <= lane_be;
                        wdata_q   <= lane_wdata;
                        cnt_q     <= '0;
                        kill_q    <= 1'b0;
                        bus_req_q <= 1'b1;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_d;
                    if (flush) begin
                        kill_q <= 1'b1;
                    end
                    if (done) begin
                        bus_req_q <= 1'b0;
                        kill_q    <= 1'b0;
                        if (killed) begin
                            state_q <= IDLE;
                        end else begin
                            state_q       <= RESP;
                            rsp_valid_q   <= 1'b1;
                            rsp_err_q     <= to_hit;
                            rsp_rdata_q   <= (ack_hit && !we_q) ? bus.bus_rdata : 32'h0;
                            rsp_addr_lo_q <= addr_lo_q;
                            rsp_width_q   <= width_q;
                            rsp_signed_q  <= signed_q;
                        end
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed requests with a scripted bus slave;
// expected responses are queued when a request is issued and compared when
// rsp_valid pulses.
module tb_mem_access_ctrl;
    import cpu_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_we, req_signed, flush;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_width;
    logic        stall, exc_adel, exc_ades;
    logic        rsp_valid, rsp_err, rsp_signed;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_addr_lo, rsp_width;

    mem_access_ctrl_if bus_if ();

    mem_access_ctrl #(.TIMEOUT_CYC(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_width   (req_width),
        .req_signed  (req_signed),
        .req_wdata   (req_wdata),
        .flush       (flush),
        .stall       (stall),
        .exc_adel    (exc_adel),
        .exc_ades    (exc_ades),
        .bus         (bus_if),
        .rsp_valid   (rsp_valid),
        .rsp_err     (rsp_err),
        .rsp_rdata   (rsp_rdata),
        .rsp_addr_lo (rsp_addr_lo),
        .rsp_width   (rsp_width),
        .rsp_signed  (rsp_signed)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        logic [1:0]  lo;
        logic [1:0]  w;
        logic        sgn;
    } rsp_t;

    rsp_t sb_q[$];

    // Scoreboard: every response pulse must match the oldest queued expectation
    always @(negedge clk) begin
        rsp_t e;
        #2;
        if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", {31'b0, rsp_valid}, 32'h0);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_meta", {26'b0, rsp_err, rsp_addr_lo, rsp_width, rsp_signed},
                    {26'b0, e.err, e.lo, e.w, e.sgn});
            end
        end
    end

    // Observations of the last run_req call
    int          r_stall, r_breq;
    logic        r_rsp, r_adel, r_ades, r_done, r_we;
    logic [3:0]  r_be;
    logic [31:0] r_wd, r_addr;

    task automatic idle_cycle();
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0; req_signed = 1'b0; flush = 1'b0;
        req_addr = 32'h0; req_width = 2'b00; req_wdata = 32'h0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
        #1;
    endtask

    // Cycle 0 presents the request; bus_ack is given on cycle ack_at (never if <0),
    // flush on cycle flush_at. Ends on the first cycle with stall low.
    task automatic run_req(input logic we, input logic [31:0] addr, input logic [1:0] w,
                           input logic sgn, input logic [31:0] d, input int ack_at,
                           input logic [31:0] rd, input int flush_at, input logic expect_rsp);
        rsp_t e;
        r_stall = 0; r_breq = 0; r_rsp = 1'b0; r_adel = 1'b0; r_ades = 1'b0; r_done = 1'b0;
        r_be = 4'h0; r_wd = 32'h0; r_addr = 32'h0; r_we = 1'b0;
        if (expect_rsp) begin
            e.err   = (ack_at < 0);
            e.rdata = (we || ack_at < 0) ? 32'h0 : rd;
            e.lo    = addr[1:0];
            e.w     = w;
            e.sgn   = sgn;
            sb_q.push_back(e);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req_valid = 1'b1; req_we = we; req_addr = addr;
                req_width = w; req_signed = sgn; req_wdata = d;
            end
            bus_if.bus_ack   = (k == ack_at);
            bus_if.bus_rdata = (k == ack_at) ? rd : 32'h0;
            flush            = (k == flush_at);
            #1;
            if (stall) r_stall++;
            if (bus_if.bus_req) r_breq++;
            if (rsp_valid) r_rsp = 1'b1;
            if (k == 0) begin
                r_adel = exc_adel;
                r_ades = exc_ades;
            end
            if (k == 1) begin
                r_be = bus_if.bus_be; r_wd = bus_if.bus_wdata;
                r_addr = bus_if.bus_addr; r_we = bus_if.bus_we;
            end
            if (!stall) begin
                req_valid = 1'b0;
                flush = 1'b0;
                r_done = 1'b1;
                break;
            end
        end
        chk("req_terminates", {31'b0, r_done}, 32'h1);
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_signed = 1'b0; flush = 1'b0;
        req_addr = 32'h0; req_width = 2'b00; req_wdata = 32'h0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_bus_req", {31'b0, bus_if.bus_req}, 32'h0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_bus_be", {28'b0, bus_if.bus_be}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Load word, ack three cycles after the request
        run_req(1'b0, 32'h1004, WIDTH_WORD, 1'b0, 32'h0, 3, 32'hDEADBEEF, -1, 1'b1);
        chk("t1_stall_cycles", r_stall, 4);
        chk("t1_bus_req_cycles", r_breq, 3);
        chk("t1_rsp_seen", {31'b0, r_rsp}, 32'h1);
        chk("t1_bus_be", {28'b0, r_be}, 32'hF);
        chk("t1_bus_addr", r_addr, 32'h1004);
        chk("t1_bus_we", {31'b0, r_we}, 32'h0);
        idle_cycle();
        chk("t1_rsp_hold", rsp_rdata, 32'hDEADBEEF);

        // Store byte at lane 3, minimum latency; read data on ack must not leak
        run_req(1'b1, 32'h2003, WIDTH_BYTE, 1'b0, 32'h000000A5, 1, 32'h12345678, -1, 1'b1);
        chk("t2_bus_be", {28'b0, r_be}, 32'h8);
        chk("t2_bus_wdata", r_wd, 32'hA5A5A5A5);
        chk("t2_bus_addr", r_addr, 32'h2000);
        chk("t2_bus_we", {31'b0, r_we}, 32'h1);
        chk("t2_stall_cycles", r_stall, 2);
        idle_cycle();

        // Store half, upper lanes
        run_req(1'b1, 32'h2002, WIDTH_HALF, 1'b0, 32'h1234ABCD, 2, 32'h0, -1, 1'b1);
        chk("t2b_bus_be", {28'b0, r_be}, 32'hC);
        chk("t2b_bus_wdata", r_wd, 32'hABCDABCD);
        idle_cycle();

        // Signed byte load at lane 1
        run_req(1'b0, 32'h2001, WIDTH_BYTE, 1'b1, 32'h0, 1, 32'h11223344, -1, 1'b1);
        chk("t2c_bus_be", {28'b0, r_be}, 32'h2);
        chk("t2c_bus_we", {31'b0, r_we}, 32'h0);
        idle_cycle();

        // Misaligned accesses raise an exception and never reach the bus
        run_req(1'b0, 32'h3001, WIDTH_HALF, 1'b0, 32'h0, -1, 32'h0, -1, 1'b0);
        chk("t3_adel", {30'b0, r_adel, r_ades}, 32'h2);
        chk("t3_stall", r_stall, 0);
        idle_cycle();
        chk("t3_no_bus_req", {31'b0, bus_if.bus_req}, 32'h0);
        run_req(1'b1, 32'h3002, WIDTH_WORD, 1'b0, 32'h55, -1, 32'h0, -1, 1'b0);
        chk("t3_ades", {30'b0, r_adel, r_ades}, 32'h1);
        idle_cycle();
        chk("t3_no_bus_req2", {31'b0, bus_if.bus_req}, 32'h0);
        run_req(1'b0, 32'h4000, 2'b11, 1'b0, 32'h0, -1, 32'h0, -1, 1'b0);
        chk("t3_width11_adel", {30'b0, r_adel, r_ades}, 32'h2);
        idle_cycle();

        // Timeout: no ack for TIMEOUT_CYC busy cycles
        run_req(1'b0, 32'h5000, WIDTH_WORD, 1'b0, 32'h0, -1, 32'h0, -1, 1'b1);
        chk("t4_bus_req_cycles", r_breq, 8);
        chk("t4_stall_cycles", r_stall, 9);
        chk("t4_rsp_seen", {31'b0, r_rsp}, 32'h1);
        idle_cycle();
        chk("t4_rsp_err_hold", {31'b0, rsp_err}, 32'h1);

        // Flush while busy: transaction completes silently, stall drops on the ack cycle
        run_req(1'b0, 32'h6000, WIDTH_WORD, 1'b0, 32'h0, 3, 32'h99999999, 1, 1'b0);
        chk("t5_stall_cycles", r_stall, 3);
        chk("t5_bus_req_cycles", r_breq, 3);
        chk("t5_no_rsp", {31'b0, r_rsp}, 32'h0);
        idle_cycle();
        chk("t5_idle_no_rsp", {31'b0, rsp_valid}, 32'h0);
        run_req(1'b0, 32'h6004, WIDTH_WORD, 1'b0, 32'h0, 1, 32'hCAFEF00D, -1, 1'b1);
        chk("t5_next_rsp", {31'b0, r_rsp}, 32'h1);
        chk("t5_next_stall", r_stall, 2);
        idle_cycle();

        // Asynchronous reset in the middle of a bus access
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h7000; req_width = WIDTH_WORD;
        #1;
        @(negedge clk);
        #1;
        chk("t6_bus_req_busy", {31'b0, bus_if.bus_req}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("t6_bus_req_rst", {31'b0, bus_if.bus_req}, 32'h0);
        chk("t6_stall_rst", {31'b0, stall}, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        reset_n = 1'b1;
        run_req(1'b0, 32'h10, WIDTH_HALF, 1'b1, 32'h0, 2, 32'hBEEF8000, -1, 1'b1);
        chk("t6_rsp_seen", {31'b0, r_rsp}, 32'h1);
        chk("t6_rsp_width", {30'b0, rsp_width}, 32'h1);
        chk("t6_rsp_signed", {31'b0, rsp_signed}, 32'h1);
        idle_cycle();
        idle_cycle();
        chk("sb_empty", sb_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
